// File: rtl/mux_scan_sequencer.sv
// Time-division scanner in front of a 4:1 mux: steps through enabled channels,
// dwells on each, samples the mux output and emits one 4-bit frame per scan.
module mux_scan_sequencer #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  input  logic [3:0] ch_mask,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic [1:0] cur_ch,
  output logic       busy,
  output logic       frame_valid,
  output logic [3:0] frame_data
);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_SCAN  = 1'b1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [3:0]    ABOVE_CH0 = 4'b1110;

  logic [0:0]    r_state;
  logic [1:0]    r_cur_ch;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_mask;
  logic [3:0]    r_shadow;
  logic          r_busy;
  logic          r_frame_valid;
  logic [3:0]    r_frame_data;

  logic [0:0]    w_state_nxt;
  logic [1:0]    w_cur_ch_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    w_mask_nxt;
  logic [3:0]    w_shadow_nxt;
  logic          w_busy_nxt;
  logic          w_frame_valid_nxt;
  logic [3:0]    w_frame_data_nxt;
  logic [3:0]    w_sampled;
  logic [3:0]    w_above;

  // Lowest set bit of a channel mask (caller guarantees non-zero).
  function automatic logic [1:0] f_first(input logic [3:0] m);
    logic [1:0] idx;
    casez (m)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cur_ch      <= 2'd0;
      r_cnt         <= '0;
      r_mask        <= 4'd0;
      r_shadow      <= 4'd0;
      r_busy        <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_data  <= 4'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_cur_ch      <= w_cur_ch_nxt;
      r_cnt         <= w_cnt_nxt;
      r_mask        <= w_mask_nxt;
      r_shadow      <= w_shadow_nxt;
      r_busy        <= w_busy_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_frame_data  <= w_frame_data_nxt;
    end
  end

  // Next state and next registered outputs; stop outranks dwell/frame end.
  always_comb begin
    w_state_nxt       = r_state;
    w_cur_ch_nxt      = r_cur_ch;
    w_cnt_nxt         = r_cnt;
    w_mask_nxt        = r_mask;
    w_shadow_nxt      = r_shadow;
    w_busy_nxt        = r_busy;
    w_frame_valid_nxt = 1'b0;
    w_frame_data_nxt  = r_frame_data;
    w_sampled         = r_shadow;
    w_sampled[r_cur_ch] = mux_out;
    w_above           = r_mask & (ABOVE_CH0 << r_cur_ch);

    case (r_state)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start && !stop && (ch_mask != 4'd0)) begin
          w_state_nxt  = ST_SCAN;
          w_mask_nxt   = ch_mask;
          w_shadow_nxt = 4'd0;
          w_cur_ch_nxt = f_first(ch_mask);
          w_cnt_nxt    = '0;
          w_busy_nxt   = 1'b1;
        end
      end
      ST_SCAN: begin
        w_busy_nxt = 1'b1;
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (w_above != 4'd0) begin
            w_shadow_nxt = w_sampled;
            w_cur_ch_nxt = f_first(w_above);
          end else begin
            w_frame_valid_nxt = 1'b1;
            w_frame_data_nxt  = w_sampled & r_mask;
            w_shadow_nxt      = 4'd0;
            if (cont) begin
              w_cur_ch_nxt = f_first(r_mask);
            end else begin
              w_state_nxt = ST_IDLE;
              w_busy_nxt  = 1'b0;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
    endcase
  end

  assign s0          = r_cur_ch[1];
  assign s1          = r_cur_ch[0];
  assign cur_ch      = r_cur_ch;
  assign busy        = r_busy;
  assign frame_valid = r_frame_valid;
  assign frame_data  = r_frame_data;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench: two sequencers (dwell 4 and dwell 2) driving behavioural 4:1 muxes.
module tb_mux_scan_sequencer;

  typedef struct packed {
    logic [3:0]  data;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, cont;
  logic [3:0]  ch_mask, mux_in;
  logic        mux_out, s0, s1, busy, frame_valid;
  logic [1:0]  cur_ch;
  logic [3:0]  frame_data;

  logic        start2, stop2, cont2;
  logic [3:0]  ch_mask2, mux_in2;
  logic        mux_out2, s0_2, s1_2, busy2, frame_valid2;
  logic [1:0]  cur_ch2;
  logic [3:0]  frame_data2;

  logic [31:0] cyc = 32'd0;
  logic [31:0] acc;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        q1[$];
  exp_t        q2[$];
  exp_t        e1, e2;

  mux_scan_sequencer #(.DWELL(4), .CW(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
    .ch_mask(ch_mask), .mux_out(mux_out), .s0(s0), .s1(s1), .cur_ch(cur_ch),
    .busy(busy), .frame_valid(frame_valid), .frame_data(frame_data)
  );

  mux_scan_sequencer #(.DWELL(2), .CW(8)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2), .cont(cont2),
    .ch_mask(ch_mask2), .mux_out(mux_out2), .s0(s0_2), .s1(s1_2), .cur_ch(cur_ch2),
    .busy(busy2), .frame_valid(frame_valid2), .frame_data(frame_data2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Behavioural mux: {s0,s1} selects A(0)..D(3).
  assign mux_out  = mux_in[{s0, s1}];
  assign mux_out2 = mux_in2[{s0_2, s1_2}];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_sel1(input string name, input logic [1:0] ch);
    check({name, " sel"}, 32'({s0, s1}), 32'(ch));
    check({name, " cur_ch"}, 32'(cur_ch), 32'(ch));
    check({name, " busy"}, 32'(busy), 32'd1);
  endtask

  task automatic check_sel2(input string name, input logic [1:0] ch);
    check({name, " sel"}, 32'({s0_2, s1_2}), 32'(ch));
    check({name, " busy"}, 32'(busy2), 32'd1);
  endtask

  task automatic start1(input logic [3:0] m, output logic [31:0] a);
    ch_mask = m;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    a       = cyc;
  endtask

  // Monitors: every frame_valid must match the head of its scoreboard.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1 unexpected frame: got data %b at cycle %0d, required none", frame_data, cyc);
      end else begin
        e1 = q1.pop_front();
        check("dut1 frame_data", 32'(frame_data), 32'(e1.data));
        check("dut1 frame cycle", cyc, e1.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (frame_valid2 === 1'b1) begin
      if (q2.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut2 unexpected frame: got data %b at cycle %0d, required none", frame_data2, cyc);
      end else begin
        e2 = q2.pop_front();
        check("dut2 frame_data", 32'(frame_data2), 32'(e2.data));
        check("dut2 frame cycle", cyc, e2.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; ch_mask = 4'd0; mux_in = 4'd0;
    start2 = 1'b0; stop2 = 1'b0; cont2 = 1'b0; ch_mask2 = 4'd0; mux_in2 = 4'd0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset sel", 32'({s0, s1}), 32'd0);
    check("reset cur_ch", 32'(cur_ch), 32'd0);
    check("reset frame_valid", 32'(frame_valid), 32'd0);
    check("reset frame_data", 32'(frame_data), 32'd0);
    check("reset busy2", 32'(busy2), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full scan, A=1 B=0 C=1 D=1
    mux_in = 4'b1101;
    start1(4'b1111, acc);
    q1.push_back('{data: 4'b1101, cyc: acc + 32'd16});
    for (int k = 0; k < 16; k++) begin
      check_sel1("full", 2'(k / 4));
      @(negedge clk);
    end
    check("full cur_ch hold", 32'(cur_ch), 32'd3);
    @(negedge clk);
    check("full busy after frame", 32'(busy), 32'd0);

    // Sparse mask: only B then D visited
    mux_in = 4'b0110;
    start1(4'b1010, acc);
    q1.push_back('{data: 4'b0010, cyc: acc + 32'd8});
    for (int k = 0; k < 8; k++) begin
      check_sel1("sparse", (k < 4) ? 2'd1 : 2'd3);
      @(negedge clk);
    end
    @(negedge clk);
    check("sparse busy after frame", 32'(busy), 32'd0);

    // Stop during the C dwell
    mux_in = 4'b1111;
    start1(4'b1111, acc);
    repeat (9) @(negedge clk);
    check_sel1("stop mid", 2'd2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop mid busy", 32'(busy), 32'd0);
    check("stop mid frame_valid", 32'(frame_valid), 32'd0);
    check("stop mid frame_data", 32'(frame_data), 32'b0010);
    check("stop mid cur_ch hold", 32'(cur_ch), 32'd2);
    repeat (10) @(negedge clk);
    check("stop mid stays idle", 32'(busy), 32'd0);

    // Stop coinciding with the final dwell edge
    start1(4'b1111, acc);
    repeat (15) @(negedge clk);
    check_sel1("stop final", 2'd3);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop final busy", 32'(busy), 32'd0);
    check("stop final frame_valid", 32'(frame_valid), 32'd0);
    check("stop final frame_data", 32'(frame_data), 32'b0010);
    repeat (4) @(negedge clk);

    // Ignored starts: empty mask, and start together with stop
    ch_mask = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero mask busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("zero mask busy later", 32'(busy), 32'd0);
    ch_mask = 4'b1111;
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    check("start+stop busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);

    // Start and mask change while busy are ignored
    mux_in = 4'b0111;
    start1(4'b0101, acc);
    q1.push_back('{data: 4'b0101, cyc: acc + 32'd8});
    repeat (2) @(negedge clk);
    ch_mask = 4'b1010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_sel1("busy start", 2'd0);
    repeat (2) @(negedge clk);
    check_sel1("busy start ch2", 2'd2);
    repeat (4) @(negedge clk);
    check("busy start idle after", 32'(busy), 32'd0);

    // Continuous mode on the dwell-2 instance
    mux_in2 = 4'b0001;
    cont2 = 1'b1;
    ch_mask2 = 4'b0011;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    acc = cyc;
    q2.push_back('{data: 4'b0001, cyc: acc + 32'd4});
    q2.push_back('{data: 4'b0010, cyc: acc + 32'd8});
    q2.push_back('{data: 4'b0011, cyc: acc + 32'd12});
    check_sel2("cont k0", 2'd0);
    repeat (2) @(negedge clk);
    check_sel2("cont k2", 2'd1);
    repeat (2) @(negedge clk);
    mux_in2 = 4'b0010;
    check_sel2("cont wrap", 2'd0);
    repeat (4) @(negedge clk);
    mux_in2 = 4'b0011;
    check_sel2("cont wrap2", 2'd0);
    repeat (2) @(negedge clk);
    cont2 = 1'b0;
    repeat (3) @(negedge clk);
    check("cont dropped busy", 32'(busy2), 32'd0);
    repeat (8) @(negedge clk);

    // Asynchronous reset mid-scan
    start1(4'b1111, acc);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst mid busy", 32'(busy), 32'd0);
    check("rst mid sel", 32'({s0, s1}), 32'd0);
    check("rst mid frame_valid", 32'(frame_valid), 32'd0);
    check("rst mid frame_data", 32'(frame_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst mid stays idle", 32'(busy), 32'd0);
    check("rst mid cur_ch", 32'(cur_ch), 32'd0);

    repeat (20) @(negedge clk);
    check("dut1 frames outstanding", 32'(q1.size()), 32'd0);
    check("dut2 frames outstanding", 32'(q2.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Sequential controller that sits directly upstream of the 4:1 select mux and drives its s0/s1 select lines.
- Steps through the enabled input channels, holds each one for a programmable dwell time, and samples the mux output at the end of each dwell.
- Assembles one 4-bit frame per scan and presents it with a one-cycle valid pulse.
- Turns the combinational mux into a time-division scanner.

Parameters:
- DWELL, 4, cycles each channel is held before sampling; legal values 1..255.
- CW, 8, dwell counter width; must satisfy 2^CW > DWELL.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- stop  input  1  abort the scan; effective on the next edge.
- cont  input  1  continuous mode; sampled at each frame end.
- ch_mask  input  4  channel enables; bit i enables channel i; latched on an accepted start.
- mux_out  input  1  output of the downstream 4:1 mux (combinational path).
- s0  output  1  mux select MSB; equals cur_ch[1].
- s1  output  1  mux select LSB; equals cur_ch[0].
- cur_ch  output  2  channel currently selected (0=A, 1=B, 2=C, 3=D).
- busy  output  1  high while scanning.
- frame_valid  output  1  one-cycle pulse when frame_data updates.
- frame_data  output  4  bit i = sampled value of channel i; disabled channels read 0.

Behaviour:
- Reset (async, any state): state=IDLE; cur_ch, s0, s1, busy, frame_valid, frame_data, counter, mask latch and shadow register all 0.
- All outputs are registered. s0/s1 change only on clock edges. mux_out is sampled at the edge that ends a dwell.
- IDLE:
  - busy=0; cur_ch holds its last value.
  - start=1, stop=0 and ch_mask!=0 -> latch the mask, clear the shadow register, cur_ch = lowest enabled channel, cnt=0, go to SCAN.
  - start with ch_mask=0 is ignored.
- SCAN:
  - busy=1; cnt increments each cycle.
  - When cnt==DWELL-1: shadow[cur_ch] <= mux_out.
  - If a higher enabled channel remains: move cur_ch to the next enabled index, cnt=0.
  - Otherwise (last channel): frame_data <= shadow with the new bit merged (disabled bits 0), frame_valid=1 for that one cycle.
  - At the last channel, if cont=1: cur_ch = lowest enabled channel, cnt=0, stay in SCAN with no idle gap, reusing the latched mask.
  - At the last channel, if cont=0: go to IDLE.
- Frame timing:
  - Frame period = popcount(mask) * DWELL cycles.
  - The first frame_valid is seen N*DWELL cycles after the start-accept edge.
- stop=1 in SCAN:
  - Next edge goes to IDLE. No sample is taken and no frame_valid is issued.
  - frame_data keeps its previous value.
  - stop takes priority over a simultaneous dwell-end or frame-end.
- start=1 and stop=1 together in IDLE: stay in IDLE.
- start while busy is ignored. ch_mask changes while busy have no effect until the next accepted start.
- DWELL=1: a channel change every cycle. cnt must not overflow for the maximum DWELL.
- Reset mid-scan: immediate return to reset values, no frame emitted.

Test Plan:
- Reset mid-scan:
  - Assert rst asynchronously mid-SCAN.
  - Same cycle: busy=0, s0=s1=0, frame_valid=0, frame_data=0. After release it stays IDLE until start.
- Full scan, DWELL=4, mask=1111:
  - Mux model inputs A=1, B=0, C=1, D=1; pulse start.
  - {s0,s1} = 00, 01, 10, 11, each held 4 cycles.
  - frame_valid pulses once, 16 cycles after accept; frame_data=4'b1101; busy falls the next cycle.
- Sparse mask=1010, DWELL=4:
  - Only ch1 then ch3 are visited ({s0,s1}=01, then 11).
  - frame_valid after 8 cycles; frame_data bits 0 and 2 are 0.
- Continuous mode, mask=0011, DWELL=2, cont=1:
  - frame_valid every 4 cycles with no gap.
  - Change A between frames: frame_data follows.
  - Drop cont: returns to IDLE after the current frame.
- Stop mid-scan:
  - Assert stop during ch2 dwell.
  - Next edge busy=0, no frame_valid, frame_data holds the prior frame.
  - stop coinciding with the final dwell edge also suppresses the frame.
- Ignored starts:
  - start with mask=0 -> busy stays 0.
  - start pulses while busy, and a mask change mid-scan -> no restart, the original mask is used.
